button_conditioner: RTL
=======================

Name: button_conditioner

Overview:
- Parametrised N-channel push-button front end; successor to the two-button handler.
- Per channel: synchroniser, counter-based debouncer, press/release edge pulses, optional auto-repeat.
- Sits between board buttons and control logic (counter advance, SPI send start); all outputs are in the clk_100 domain.

Parameters:
- N_BTN, 2, number of independent button channels (>=1).
- SYNC_STAGES, 2, flip-flop synchroniser depth (>=2).
- DEBOUNCE_CYCLES, 1000000, consecutive clk_100 cycles the synchronised input must differ from the accepted level before it is accepted (10 ms at 100 MHz; >=1).
- REPEAT_DELAY, 50000000, cycles from press pulse to first auto-repeat pulse (>=1).
- REPEAT_PERIOD, 10000000, cycles between subsequent auto-repeat pulses (>=1).
- ACTIVE_LOW, 0, 1 = btn_i pressed when low (inverted before the synchroniser).

Ports:
- clk_100, input, 1, system clock.
- a_rst, input, 1, asynchronous active-high reset.
- s_rst, input, 1, synchronous active-high clear; same effect as a_rst, applied on the clock edge.
- btn_i, input, N_BTN, raw asynchronous button pins.
- repeat_en_i, input, N_BTN, per-channel auto-repeat enable (clk_100 domain).
- level_o, output, N_BTN, debounced pressed level.
- press_o, output, N_BTN, one-cycle pulse on accepted press and on each auto-repeat tick.
- release_o, output, N_BTN, one-cycle pulse on accepted release.

Behaviour:
- Reset (a_rst async, or s_rst at the edge): sync chains hold the not-pressed value; debounce and repeat counters are 0; level_o, press_o and release_o are 0. Reset clears all state even mid-count or mid-hold.
- Channels are fully independent. No cross-channel priority; simultaneous events produce simultaneous pulses.
- Synchroniser: SYNC_STAGES registers per channel; their output is s[i] (polarity already normalised).
- Debounce, each edge:
  - if s[i] == level_o[i]: cnt <= 0.
  - else if cnt == DEBOUNCE_CYCLES-1: level_o[i] <= s[i]; cnt <= 0.
  - else: cnt <= cnt+1.
- Counter width: $clog2(DEBOUNCE_CYCLES+1).
- Latency: level_o changes exactly SYNC_STAGES+DEBOUNCE_CYCLES edges after the first edge that samples the new btn_i value (that edge counts as 1), provided the input stays stable.
- Any return of s[i] to level_o[i] before acceptance restarts the count; a glitch shorter than DEBOUNCE_CYCLES after synchronisation never changes level_o.
- Edge pulses: press_o[i] is high for exactly one cycle, the first cycle level_o[i] is 1. release_o[i] is high for exactly one cycle, the first cycle level_o[i] is 0 after being 1. Both are registered, with no combinational path from inputs.
- Auto-repeat, per channel, with states IDLE, DELAY, PERIOD:
  - IDLE: left on press (rep_cnt <= 0, go to DELAY) if repeat_en_i[i] = 1; otherwise stays IDLE.
  - DELAY: rep_cnt counts cycles after the press pulse. At the edge where rep_cnt reaches REPEAT_DELAY-1: press_o pulse in the following cycle, rep_cnt <= 0, go to PERIOD.
  - PERIOD: same rule with REPEAT_PERIOD.
  - Result: pulses at cycles P, P+REPEAT_DELAY, P+REPEAT_DELAY+REPEAT_PERIOD, and so on, where P is the press pulse cycle.
  - level_o[i] falling or repeat_en_i[i] = 0 in any state: go to IDLE and clear rep_cnt. Re-enabling while held does not restart repeat; the next press is needed.
  - rep_cnt width: $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1).
- Release during a repeat tick cycle: the tick is suppressed; release_o still pulses. press_o and release_o are never high together on one channel.

Test Plan:
- Bench parameters for all scenarios: N_BTN=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
1. Clean press: btn_i[0] rises before edge 1, held 40 cycles, repeat_en=0 -> level_o[0] rises at edge 6; press_o[0] high only in that cycle; channel 1 outputs stay 0.
2. Glitches and bounce: btn_i[0] high for 3 cycles -> no level change. Toggle every 2 cycles for 20 cycles, then stable high -> a single press_o pulse, 6 edges after the first stable sampling edge.
3. Auto-repeat: repeat_en_i[0]=1, hold 30 cycles past press pulse P -> press_o[0] at P, P+10, P+13, P+16, ..., P+28. Drop repeat_en at P+14 -> no further ticks.
4. Release: after scenario 1, btn_i[0] falls -> level_o[0] falls 6 edges later; release_o[0] pulses once; no press_o in that cycle; repeat stops.
5. Simultaneous: both channels pressed on the same cycle with repeat_en=2'b11 -> identical, same-cycle press_o and repeat pulses on both bits.
6. Reset mid-operation: a_rst pulsed (asynchronously) at P+5 while held, and separately s_rst for one cycle -> all outputs 0 immediately or at the edge. Button still held after deassertion -> press re-detected 6 edges later. Also run ACTIVE_LOW=1 with an inverted stimulus -> identical responses.

Source files
------------

// File: rtl/button_conditioner.sv
// button_conditioner
//   N-channel push-button front end. Each channel synchronises its raw pin
//   into the clk_100 domain, debounces it with a consecutive-cycle counter,
//   emits one-cycle press/release pulses and optionally auto-repeats press
//   pulses while the button stays held.
//
// Ports
//   clk_100     : system clock
//   a_rst       : asynchronous active-high reset
//   s_rst       : synchronous active-high clear (same effect as a_rst)
//   btn_i       : raw asynchronous button pins, one per channel
//   repeat_en_i : per-channel auto-repeat enable (clk_100 domain)
//   level_o     : debounced pressed level
//   press_o     : one-cycle pulse on accepted press and on each repeat tick
//   release_o   : one-cycle pulse on accepted release
module button_conditioner #(
    parameter int N_BTN           = 2,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic             clk_100,
    input  logic             a_rst,
    input  logic             s_rst,
    input  logic [N_BTN-1:0] btn_i,
    input  logic [N_BTN-1:0] repeat_en_i,
    output logic [N_BTN-1:0] level_o,
    output logic [N_BTN-1:0] press_o,
    output logic [N_BTN-1:0] release_o
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [REP_W-1:0] DLY_LAST = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] PER_LAST = REP_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        REP_IDLE   = 2'd0,
        REP_DELAY  = 2'd1,
        REP_PERIOD = 2'd2
    } rep_state_t;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        logic                   raw;
        logic [SYNC_STAGES-1:0] sync_p0;
        logic                   s;
        logic [DB_W-1:0]        db_cnt;
        logic [DB_W-1:0]        db_cnt_nxt;
        logic                   lvl_p1;
        logic                   press_p1;
        logic                   release_p1;
        logic                   accept;
        logic                   press_evt;
        logic                   release_evt;
        logic                   tick;
        rep_state_t             rep_state;
        rep_state_t             rep_state_nxt;
        logic [REP_W-1:0]       rep_cnt;
        logic [REP_W-1:0]       rep_cnt_nxt;

        // Polarity is normalised before the synchroniser so everything
        // downstream treats 1 as "pressed".
        assign raw = ACTIVE_LOW ? ~btn_i[i] : btn_i[i];
        assign s   = sync_p0[SYNC_STAGES-1];

        always_comb begin
            accept        = (s != lvl_p1) && (db_cnt == DB_LAST);
            press_evt     = accept && s;
            release_evt   = accept && !s;
            db_cnt_nxt    = db_cnt + 1'b1;
            rep_state_nxt = rep_state;
            rep_cnt_nxt   = rep_cnt;
            tick          = 1'b0;

            if (s == lvl_p1 || accept) begin
                db_cnt_nxt = '0;
            end

            case (rep_state)
                REP_IDLE: begin
                    // Entered on the acceptance edge, so rep_cnt is 0 in the
                    // press pulse cycle and counts cycles since it.
                    if (press_evt && repeat_en_i[i]) begin
                        rep_state_nxt = REP_DELAY;
                        rep_cnt_nxt   = '0;
                    end
                end
                REP_DELAY, REP_PERIOD: begin
                    // A release on the tick edge wins: the tick is dropped.
                    if (!repeat_en_i[i] || release_evt || !lvl_p1) begin
                        rep_state_nxt = REP_IDLE;
                        rep_cnt_nxt   = '0;
                    end else if (rep_cnt == ((rep_state == REP_DELAY) ? DLY_LAST : PER_LAST)) begin
                        tick          = 1'b1;
                        rep_state_nxt = REP_PERIOD;
                        rep_cnt_nxt   = '0;
                    end else begin
                        rep_cnt_nxt = rep_cnt + 1'b1;
                    end
                end
                default: begin
                    rep_state_nxt = REP_IDLE;
                    rep_cnt_nxt   = '0;
                end
            endcase
        end

        // ---- synchroniser / debounce / pulse / repeat registers ----
        always_ff @(posedge clk_100 or posedge a_rst) begin
            if (a_rst) begin
                sync_p0    <= '0;
                db_cnt     <= '0;
                lvl_p1     <= 1'b0;
                press_p1   <= 1'b0;
                release_p1 <= 1'b0;
                rep_state  <= REP_IDLE;
                rep_cnt    <= '0;
            end else if (s_rst) begin
                sync_p0    <= '0;
                db_cnt     <= '0;
                lvl_p1     <= 1'b0;
                press_p1   <= 1'b0;
                release_p1 <= 1'b0;
                rep_state  <= REP_IDLE;
                rep_cnt    <= '0;
            end else begin
                sync_p0    <= {sync_p0[SYNC_STAGES-2:0], raw};
                db_cnt     <= db_cnt_nxt;
                lvl_p1     <= accept ? s : lvl_p1;
                press_p1   <= press_evt || tick;
                release_p1 <= release_evt;
                rep_state  <= rep_state_nxt;
                rep_cnt    <= rep_cnt_nxt;
            end
        end

        assign level_o[i]   = lvl_p1;
        assign press_o[i]   = press_p1;
        assign release_o[i] = release_p1;
    end

endmodule
